// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8N1 frame recovery into a one-entry holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote over the three ticks ending at each bit centre.
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_tick,
   input  logic       rx,
   input  logic       rd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t                 state_r, next_state_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic [TW-1:0]          tick_cnt_r, tick_cnt_nxt_s;
   logic [2:0]             bit_cnt_r, bit_cnt_nxt_s;
   logic [7:0]             shift_r, shift_nxt_s;
   logic [7:0]             data_r;
   logic                   valid_r, frame_err_r, overrun_r, busy_r;
   logic                   rxs_s, bit_s, commit_s;

   assign rxs_s     = sync_r[SYNC_STAGES-1];
   assign data      = data_r;
   assign valid     = valid_r;
   assign frame_err = frame_err_r;
   assign overrun   = overrun_r;
   assign busy      = busy_r;

   // Input synchronizer, preset high so the line reads idle out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_r;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Two previous tick samples; with the current one they span the ticks ending at the centre.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_r <= 2'b11;
      end else if (sample_tick) begin
         hist_r <= {hist_r[0], rxs_s};
      end else begin
         hist_r <= hist_r;
      end
   end

   assign bit_s = maj3(hist_r[1], hist_r[0], rxs_s);
`else
   assign bit_s = rxs_s;
`endif

   // Next-state, counter and shift-register decode; everything advances only on a tick.
   always_comb begin
      next_state_s   = state_r;
      tick_cnt_nxt_s = tick_cnt_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      shift_nxt_s    = shift_r;
      commit_s       = 1'b0;
      if (sample_tick) begin
         case (state_r)
            ST_IDLE: begin
               if (!rxs_s) begin
                  next_state_s   = ST_START;
                  tick_cnt_nxt_s = TICK_ZERO;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_START: begin
               if (tick_cnt_r == TICK_MID) begin
                  tick_cnt_nxt_s = TICK_ZERO;
                  bit_cnt_nxt_s  = 3'd0;
                  next_state_s   = bit_s ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
               end
            end
            ST_DATA: begin
               if (tick_cnt_r == TICK_END) begin
                  shift_nxt_s    = {bit_s, shift_r[7:1]};
                  tick_cnt_nxt_s = TICK_ZERO;
                  bit_cnt_nxt_s  = bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     next_state_s = ST_STOP;
                  end else begin
                     next_state_s = ST_DATA;
                  end
               end else begin
                  tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
               end
            end
            ST_STOP: begin
               if (tick_cnt_r == TICK_END) begin
                  commit_s       = 1'b1;
                  tick_cnt_nxt_s = TICK_ZERO;
                  next_state_s   = bit_s ? ST_IDLE : ST_BREAK;
               end else begin
                  tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
               end
            end
            ST_BREAK: begin
               // A held-low line must go high before another start can be seen.
               if (rxs_s) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_BREAK;
               end
            end
            default: begin
               next_state_s   = ST_IDLE;
               tick_cnt_nxt_s = TICK_ZERO;
               bit_cnt_nxt_s  = 3'd0;
            end
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   // FSM state, counters and shift register; busy tracks the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         tick_cnt_r <= TICK_ZERO;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         tick_cnt_r <= tick_cnt_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         shift_r    <= shift_nxt_s;
         busy_r     <= (next_state_s != ST_IDLE);
      end
   end

   // Holding register and status; a commit takes priority over a same-edge read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r      <= 8'h00;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else if (commit_s) begin
         data_r      <= shift_r;
         valid_r     <= 1'b1;
         frame_err_r <= ~bit_s;
         overrun_r   <= overrun_r | (valid_r & ~rd);
      end else if (rd && valid_r) begin
         data_r      <= data_r;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         data_r      <= data_r;
         valid_r     <= valid_r;
         frame_err_r <= frame_err_r;
         overrun_r   <= overrun_r;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of clean frames plus hand sequences for the corner cases.
module tb_uart_rx;

   logic       clk, rst_n, sample_tick, rx, rd;
   logic [7:0] data;
   logic       valid, frame_err, overrun, busy;
   int         cyc, n_cmp, n_fail, rises;
   logic       valid_q;

   typedef struct packed {
      logic [7:0] din;
      logic [7:0] exp_data;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t vecs [6];

   uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx(rx), .rd(rd),
      .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick on every 4th clk; cyc % 4 == 0 means the coming rising edge carries a tick.
   initial begin
      cyc = 0;
      sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         sample_tick = (cyc % 4 == 0);
      end
   end

   initial begin
      rises = 0;
      valid_q = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (valid === 1'b1 && valid_q !== 1'b1) rises = rises + 1;
         valid_q = valid;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic align();
      step();
      while (cyc % 4 != 0) step();
   endtask

   task automatic pulse_rd();
      step();
      rd = 1'b1;
      step();
      rd = 1'b0;
   endtask

   // One frame, 64 clk per bit; c counts clks from the start edge. Commit edge is c = 612.
   task automatic send_frame(input logic [7:0] d, input logic stop_val, input int n_stop,
                             input int rd_at, output logic v_pre, output logic v_post,
                             output logic busy_mid);
      int len;
      int bitpos;
      len = (9 + n_stop) * 64;
      v_pre = 1'b0;
      v_post = 1'b0;
      busy_mid = 1'b0;
      align();
      for (int c = 0; c < len; c++) begin
         if (c > 0) step();
         if (c == 612) v_pre = valid;
         if (c == 613) v_post = valid;
         if (c == 704) busy_mid = busy;
         bitpos = c / 64;
         if (bitpos == 0) rx = 1'b0;
         else if (bitpos <= 8) rx = d[bitpos-1];
         else rx = stop_val;
         rd = (c == rd_at);
      end
   endtask

   initial begin
      logic vp, vq, bm, gb;
      int   r0;
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      rx = 1'b1;
      rd = 1'b0;
      vecs[0] = '{din: 8'hA5, exp_data: 8'hA5, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[1] = '{din: 8'h00, exp_data: 8'h00, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[3] = '{din: 8'h5A, exp_data: 8'h5A, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[4] = '{din: 8'h01, exp_data: 8'h01, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[5] = '{din: 8'h80, exp_data: 8'h80, exp_fe: 1'b0, exp_ov: 1'b0};

      wait_cycles(3);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", {7'd0, valid}, 8'h00);
      chk("rst_fe", {7'd0, frame_err}, 8'h00);
      chk("rst_ov", {7'd0, overrun}, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      step();
      rst_n = 1'b1;
      wait_cycles(8);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].din, 1'b1, 2, -1, vp, vq, bm);
         chk("lat_pre", {7'd0, vp}, 8'h00);
         chk("lat_post", {7'd0, vq}, 8'h01);
         chk("tbl_data", data, vecs[i].exp_data);
         chk("tbl_valid", {7'd0, valid}, 8'h01);
         chk("tbl_fe", {7'd0, frame_err}, {7'd0, vecs[i].exp_fe});
         chk("tbl_ov", {7'd0, overrun}, {7'd0, vecs[i].exp_ov});
         chk("tbl_busy", {7'd0, busy}, 8'h00);
         pulse_rd();
         chk("tbl_rd_valid", {7'd0, valid}, 8'h00);
         chk("tbl_rd_data", data, vecs[i].exp_data);
      end

      pulse_rd();
      chk("rd_empty_valid", {7'd0, valid}, 8'h00);
      chk("rd_empty_data", data, 8'h80);

      send_frame(8'h3C, 1'b1, 1, -1, vp, vq, bm);
      send_frame(8'h81, 1'b1, 1, -1, vp, vq, bm);
      chk("b2b_data", data, 8'h81);
      chk("b2b_valid", {7'd0, valid}, 8'h01);
      chk("b2b_ov", {7'd0, overrun}, 8'h01);
      chk("b2b_fe", {7'd0, frame_err}, 8'h00);
      pulse_rd();
      chk("b2b_clr_valid", {7'd0, valid}, 8'h00);
      chk("b2b_clr_ov", {7'd0, overrun}, 8'h00);
      chk("b2b_clr_fe", {7'd0, frame_err}, 8'h00);

      r0 = rises;
      send_frame(8'h55, 1'b0, 3, -1, vp, vq, bm);
      chk("brk_busy_mid", {7'd0, bm}, 8'h01);
      chk("brk_busy_end", {7'd0, busy}, 8'h01);
      step();
      rx = 1'b1;
      wait_cycles(128);
      chk("brk_busy_idle", {7'd0, busy}, 8'h00);
      chk("brk_data", data, 8'h55);
      chk("brk_fe", {7'd0, frame_err}, 8'h01);
      chk("brk_valid", {7'd0, valid}, 8'h01);
      chk("brk_ov", {7'd0, overrun}, 8'h00);
      chk("brk_commits", 8'(rises - r0), 8'h01);
      pulse_rd();
      chk("brk_clr_fe", {7'd0, frame_err}, 8'h00);

      gb = 1'b0;
      align();
      for (int c = 0; c < 20; c++) begin
         if (c > 0) step();
         if (c == 10) gb = busy;
         rx = 1'b0;
      end
      step();
      rx = 1'b1;
      chk("glitch_busy", {7'd0, gb}, 8'h01);
      wait_cycles(128);
      chk("glitch_idle", {7'd0, busy}, 8'h00);
      chk("glitch_valid", {7'd0, valid}, 8'h00);
      chk("glitch_fe", {7'd0, frame_err}, 8'h00);
      chk("glitch_ov", {7'd0, overrun}, 8'h00);
      chk("glitch_data", data, 8'h55);

      send_frame(8'hC3, 1'b1, 2, -1, vp, vq, bm);
      chk("rdc_first", data, 8'hC3);
      send_frame(8'h0F, 1'b1, 2, 612, vp, vq, bm);
      chk("rdc_valid", {7'd0, valid}, 8'h01);
      chk("rdc_data", data, 8'h0F);
      chk("rdc_ov", {7'd0, overrun}, 8'h00);
      chk("rdc_fe", {7'd0, frame_err}, 8'h00);

      align();
      for (int c = 0; c < 5 * 64; c++) begin
         if (c > 0) step();
         rx = (c < 64) ? 1'b0 : 1'b1;
      end
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data", data, 8'h00);
      chk("mid_rst_valid", {7'd0, valid}, 8'h00);
      chk("mid_rst_fe", {7'd0, frame_err}, 8'h00);
      chk("mid_rst_ov", {7'd0, overrun}, 8'h00);
      chk("mid_rst_busy", {7'd0, busy}, 8'h00);
      wait_cycles(4);
      rst_n = 1'b1;
      wait_cycles(16);
      send_frame(8'h12, 1'b1, 2, -1, vp, vq, bm);
      chk("post_rst_lat", {7'd0, vq}, 8'h01);
      chk("post_rst_data", data, 8'h12);
      chk("post_rst_valid", {7'd0, valid}, 8'h01);
      chk("post_rst_fe", {7'd0, frame_err}, 8'h00);
      chk("post_rst_ov", {7'd0, overrun}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
